// File: rtl/shift_issue_queue_if.sv
// Dispatch-in / execute-out handshake bundle for the shift issue queue.
// Latency: none, pure wiring.
// Backpressure: dispatch_ready throttles dispatch; execute_ready stalls the issued op.
interface shift_issue_queue_if #(
    parameter int INFO_DW = 144,
    parameter int TW      = 7
);
    logic               dispatch_valid;
    logic               dispatch_ready;
    logic [INFO_DW-1:0] dispatch_info;
    logic [TW-1:0]      dispatch_rs1;
    logic [TW-1:0]      dispatch_rs2;
    logic               dispatch_use_rs2;
    logic               execute_valid;
    logic               execute_ready;
    logic [INFO_DW-1:0] execute_info;
    logic [TW-1:0]      execute_rs1;
    logic [TW-1:0]      execute_rs2;

    // Environment side: produces dispatches, consumes issued ops
    modport master (
        output dispatch_valid, dispatch_info, dispatch_rs1, dispatch_rs2, dispatch_use_rs2,
        output execute_ready,
        input  dispatch_ready,
        input  execute_valid, execute_info, execute_rs1, execute_rs2
    );

    // Queue side
    modport slave (
        input  dispatch_valid, dispatch_info, dispatch_rs1, dispatch_rs2, dispatch_use_rs2,
        input  execute_ready,
        output dispatch_ready,
        output execute_valid, execute_info, execute_rs1, execute_rs2
    );
endinterface

// File: rtl/shift_issue_queue.sv
// Age-ordered compacting issue queue for shift micro-ops; issues the oldest ready entry.
// Latency: dispatch at edge N -> selectable in cycle N+1 -> execute_valid at edge N+2.
// Backpressure: dispatch_ready drops when full; issue output holds while execute_ready is low.
module shift_issue_queue #(
    parameter int DEPTH   = 4,
    parameter int INFO_DW = 144,
    parameter int RNBIT   = 2
) (
    input  logic                         i_clk,
    input  logic                         i_rstn,
    input  logic                         i_flush,
    input  logic [32*(2**RNBIT)-1:0]     i_wbLog_qout,
    output logic [$clog2(DEPTH+1)-1:0]   o_queue_count,
    shift_issue_queue_if.slave           bus
);
    localparam int TW = 5 + RNBIT;
    localparam int SW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    // Entry storage; entry 0 is the oldest, entries 0..count-1 are live
    logic [INFO_DW-1:0] r_info [DEPTH];
    logic [TW-1:0]      r_rs1  [DEPTH];
    logic [TW-1:0]      r_rs2  [DEPTH];
    logic [DEPTH-1:0]   r_use2;
    logic [CW-1:0]      r_count;

    // Issue output register
    logic               r_exe_vld;
    logic [INFO_DW-1:0] r_exe_info;
    logic [TW-1:0]      r_exe_rs1;
    logic [TW-1:0]      r_exe_rs2;

    logic [DEPTH-1:0]   w_rdy;
    logic [SW-1:0]      w_sel;
    logic               w_any;
    logic               w_pop;
    logic               w_acc;
    logic               w_dready;
    logic [SW-1:0]      w_wr_idx;

    // Readiness is recomputed every cycle from the live writeback log, never latched
    always_comb begin
        w_rdy = '0;
        for (int i = 0; i < DEPTH; i++) begin
            w_rdy[i] = (CW'(i) < r_count) && i_wbLog_qout[r_rs1[i]] &&
                       (!r_use2[i] || i_wbLog_qout[r_rs2[i]]);
        end
    end

    // Oldest ready entry = lowest ready index
    always_comb begin
        w_sel = '0;
        w_any = 1'b0;
        for (int i = DEPTH-1; i >= 0; i--) begin
            if (w_rdy[i]) begin
                w_any = 1'b1;
                w_sel = SW'(i);
            end
        end
    end

    // Dispatch readiness looks only at registered occupancy, no pop bypass
    assign w_dready = (r_count != CW'(DEPTH));
    assign w_acc    = bus.dispatch_valid && w_dready;
    assign w_pop    = w_any && (!r_exe_vld || bus.execute_ready);
    // New entry lands behind the survivors: one slot lower when an entry leaves this cycle
    assign w_wr_idx = SW'(r_count) - SW'(w_pop);

    assign bus.dispatch_ready = w_dready;
    assign bus.execute_valid  = r_exe_vld;
    assign bus.execute_info   = r_exe_info;
    assign bus.execute_rs1    = r_exe_rs1;
    assign bus.execute_rs2    = r_exe_rs2;
    assign o_queue_count      = r_count;

    // Payload storage: close the gap left by a pop, then append the dispatched op.
    // Writes during flush/reset are harmless because the count is cleared.
    always_ff @(posedge i_clk) begin
        if (w_pop) begin
            for (int i = 0; i < DEPTH-1; i++) begin
                if (SW'(i) >= w_sel) begin
                    r_info[i] <= r_info[i+1];
                    r_rs1[i]  <= r_rs1[i+1];
                    r_rs2[i]  <= r_rs2[i+1];
                    r_use2[i] <= r_use2[i+1];
                end
            end
        end
        if (w_acc) begin
            r_info[w_wr_idx] <= bus.dispatch_info;
            r_rs1[w_wr_idx]  <= bus.dispatch_rs1;
            r_rs2[w_wr_idx]  <= bus.dispatch_rs2;
            r_use2[w_wr_idx] <= bus.dispatch_use_rs2;
        end
    end

    // Occupancy and issue register; reset beats flush beats normal operation
    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            r_count    <= '0;
            r_exe_vld  <= 1'b0;
            r_exe_info <= '0;
            r_exe_rs1  <= '0;
            r_exe_rs2  <= '0;
        end else if (i_flush) begin
            r_count   <= '0;
            r_exe_vld <= 1'b0;
        end else begin
            r_count <= r_count + CW'(w_acc) - CW'(w_pop);
            if (w_pop) begin
                r_exe_vld  <= 1'b1;
                r_exe_info <= r_info[w_sel];
                r_exe_rs1  <= r_rs1[w_sel];
                r_exe_rs2  <= r_rs2[w_sel];
            end else if (bus.execute_ready) begin
                r_exe_vld <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_shift_issue_queue.sv
// Bench for shift_issue_queue: directed scenarios with literal expectations,
// then randomized traffic, all compared every cycle against a queue-based model.
// The model runs one step per clock using the inputs presented before the edge.
module tb_shift_issue_queue;
    localparam int DEPTH   = 4;
    localparam int INFO_DW = 144;
    localparam int RNBIT   = 2;
    localparam int TW      = 7;
    localparam int WL      = 128;
    localparam int CW      = 3;

    logic          clk  = 1'b0;
    logic          rstn = 1'b0;
    logic          flush = 1'b0;
    logic [WL-1:0] wb = '0;
    logic [CW-1:0] qcnt;

    shift_issue_queue_if #(.INFO_DW(INFO_DW), .TW(TW)) bus ();

    shift_issue_queue #(.DEPTH(DEPTH), .INFO_DW(INFO_DW), .RNBIT(RNBIT)) dut (
        .i_clk         (clk),
        .i_rstn        (rstn),
        .i_flush       (flush),
        .i_wbLog_qout  (wb),
        .o_queue_count (qcnt),
        .bus           (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [INFO_DW-1:0] info;
        logic [TW-1:0]      rs1;
        logic [TW-1:0]      rs2;
        logic               use2;
    } op_t;

    // Reference state: pending ops oldest-first, plus the issue register
    op_t                mq[$];
    op_t                mq_n[$];
    logic               m_ev, m_ev_n;
    logic [INFO_DW-1:0] m_ei, m_ei_n;
    logic [TW-1:0]      m_r1, m_r1_n, m_r2, m_r2_n;
    bit                 m_on = 1'b0;

    int n_checks = 0;
    int n_errs   = 0;

    task automatic chk(input string name, input logic [INFO_DW-1:0] act, input logic [INFO_DW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errs++;
            $display("FAIL %s act=%0h exp=%0h", name, act, exp);
        end
    endtask

    function automatic bit op_ready(input op_t o);
        return wb[o.rs1] && (!o.use2 || wb[o.rs2]);
    endfunction

    function automatic logic [INFO_DW-1:0] rinfo();
        logic [INFO_DW-1:0] v;
        v = '0;
        for (int i = 0; i < 5; i++) v = {v[INFO_DW-33:0], 32'($urandom)};
        return v;
    endfunction

    // One clock of the reference behaviour, from current inputs and state
    task automatic model_next();
        int k;
        bit acc, pop;
        op_t o;
        mq_n = mq; m_ev_n = m_ev; m_ei_n = m_ei; m_r1_n = m_r1; m_r2_n = m_r2;
        if (!rstn) begin
            mq_n.delete();
            m_ev_n = 1'b0; m_ei_n = '0; m_r1_n = '0; m_r2_n = '0;
        end else if (flush) begin
            mq_n.delete();
            m_ev_n = 1'b0;
        end else begin
            k = -1;
            for (int i = 0; i < mq.size(); i++)
                if (k < 0 && op_ready(mq[i])) k = i;
            acc = bus.dispatch_valid && (mq.size() != DEPTH);
            pop = (k >= 0) && (!m_ev || bus.execute_ready);
            if (pop) begin
                m_ev_n = 1'b1;
                m_ei_n = mq[k].info; m_r1_n = mq[k].rs1; m_r2_n = mq[k].rs2;
                mq_n.delete(k);
            end else if (bus.execute_ready) begin
                m_ev_n = 1'b0;
            end
            if (acc) begin
                o.info = bus.dispatch_info; o.rs1 = bus.dispatch_rs1;
                o.rs2 = bus.dispatch_rs2;   o.use2 = bus.dispatch_use_rs2;
                mq_n.push_back(o);
            end
        end
    endtask

    task automatic cyc();
        model_next();
        @(posedge clk);
        mq = mq_n; m_ev = m_ev_n; m_ei = m_ei_n; m_r1 = m_r1_n; m_r2 = m_r2_n;
        #1;
    endtask

    task automatic put(input logic [INFO_DW-1:0] info, input int rs1, input int rs2, input bit use2);
        bus.dispatch_valid   = 1'b1;
        bus.dispatch_info    = info;
        bus.dispatch_rs1     = TW'(rs1);
        bus.dispatch_rs2     = TW'(rs2);
        bus.dispatch_use_rs2 = use2;
    endtask

    task automatic idle();
        bus.dispatch_valid = 1'b0;
    endtask

    // Single compare process: DUT against model on every falling edge
    always @(negedge clk) begin
        if (m_on) begin
            chk("count",  INFO_DW'(qcnt),               INFO_DW'(mq.size()));
            chk("dready", INFO_DW'(bus.dispatch_ready), INFO_DW'(mq.size() != DEPTH));
            chk("evld",   INFO_DW'(bus.execute_valid),  INFO_DW'(m_ev));
            chk("einfo",  bus.execute_info,             m_ei);
            chk("ers1",   INFO_DW'(bus.execute_rs1),    INFO_DW'(m_r1));
            chk("ers2",   INFO_DW'(bus.execute_rs2),    INFO_DW'(m_r2));
        end
    end

    logic [INFO_DW-1:0] p [8];

    initial begin
        bus.dispatch_valid = 1'b0; bus.dispatch_info = '0; bus.dispatch_rs1 = '0;
        bus.dispatch_rs2 = '0; bus.dispatch_use_rs2 = 1'b0; bus.execute_ready = 1'b1;
        m_ev = 1'b0; m_ei = '0; m_r1 = '0; m_r2 = '0;
        for (int i = 0; i < 8; i++) p[i] = rinfo();

        // Reset
        rstn = 1'b0;
        cyc();
        m_on = 1'b1;
        cyc();
        rstn = 1'b1;
        chk("rst_count", INFO_DW'(qcnt), '0);
        chk("rst_evld",  INFO_DW'(bus.execute_valid), '0);
        chk("rst_einfo", bus.execute_info, '0);

        // Single ready op: issue two edges after dispatch
        wb[7] = 1'b1;
        put(p[0], 7, 0, 1'b0);
        cyc(); idle();
        chk("s1_evld_e1", INFO_DW'(bus.execute_valid), '0);
        chk("s1_count_e1", INFO_DW'(qcnt), INFO_DW'(1));
        cyc();
        chk("s1_evld_e2", INFO_DW'(bus.execute_valid), INFO_DW'(1));
        chk("s1_info", bus.execute_info, p[0]);
        chk("s1_count_e2", INFO_DW'(qcnt), '0);
        wb = '0;

        // Fill with unready ops, then release the middle one
        for (int i = 0; i < 4; i++) begin put(p[i], 10 + i, 0, 1'b0); cyc(); end
        idle();
        chk("s2_full_count", INFO_DW'(qcnt), INFO_DW'(4));
        chk("s2_full_dready", INFO_DW'(bus.dispatch_ready), '0);
        wb[12] = 1'b1;
        cyc();
        chk("s2_pick2", bus.execute_info, p[2]);
        chk("s2_count", INFO_DW'(qcnt), INFO_DW'(3));
        chk("s2_dready", INFO_DW'(bus.dispatch_ready), INFO_DW'(1));
        wb = '0; wb[13] = 1'b1;
        cyc();
        chk("s2_compact", bus.execute_info, p[3]);
        wb = '0;

        // Two entries ready together: oldest first
        wb[10] = 1'b1; wb[11] = 1'b1;
        cyc();
        chk("s3_first", bus.execute_info, p[0]);
        cyc();
        chk("s3_second", bus.execute_info, p[1]);
        chk("s3_count", INFO_DW'(qcnt), '0);
        wb = '0;
        cyc();

        // Execute stall holds the output
        bus.execute_ready = 1'b0;
        wb[20] = 1'b1; wb[21] = 1'b1; wb[22] = 1'b1;
        for (int i = 0; i < 3; i++) begin put(p[4 + i], 20 + i, 20 + i, 1'b1); cyc(); end
        idle();
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk("s4_hold_info", bus.execute_info, p[4]);
            chk("s4_hold_count", INFO_DW'(qcnt), INFO_DW'(2));
        end
        bus.execute_ready = 1'b1;
        cyc();
        chk("s4_drain1", bus.execute_info, p[5]);
        cyc();
        chk("s4_drain2", bus.execute_info, p[6]);
        cyc();
        chk("s4_empty", INFO_DW'(bus.execute_valid), '0);
        wb = '0;

        // Full queue: pop plus dispatch attempt in the same cycle
        for (int i = 0; i < 4; i++) begin put(p[i], 30 + i, 0, 1'b0); cyc(); end
        wb[31] = 1'b1;
        put(p[7], 50, 0, 1'b0);
        cyc(); idle();
        chk("s5_count", INFO_DW'(qcnt), INFO_DW'(3));
        chk("s5_info", bus.execute_info, p[1]);
        wb = '1;
        repeat (5) cyc();
        chk("s5_drained", INFO_DW'(qcnt), '0);
        wb = '0;
        cyc();

        // Flush, then reset, each with three queued ops, a held issue and a concurrent dispatch
        for (int pass = 0; pass < 2; pass++) begin
            bus.execute_ready = 1'b0;
            wb = '0; wb[40] = 1'b1;
            for (int i = 0; i < 4; i++) begin put(p[i], 40 + i, 0, 1'b0); cyc(); end
            chk("s6_pre_count", INFO_DW'(qcnt), INFO_DW'(3));
            chk("s6_pre_evld", INFO_DW'(bus.execute_valid), INFO_DW'(1));
            put(p[4], 44, 0, 1'b0);
            wb = '1; bus.execute_ready = 1'b1;
            if (pass == 0) flush = 1'b1; else rstn = 1'b0;
            cyc();
            flush = 1'b0; rstn = 1'b1; idle();
            chk("s6_count", INFO_DW'(qcnt), '0);
            chk("s6_evld", INFO_DW'(bus.execute_valid), '0);
            if (pass == 1) chk("s6_rst_info", bus.execute_info, '0);
            for (int i = 0; i < 5; i++) begin
                cyc();
                chk("s6_no_issue", INFO_DW'(bus.execute_valid), '0);
            end
        end

        // Randomized traffic
        wb = '0;
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 2) != 0)
                put(rinfo(), $urandom_range(0, 15), $urandom_range(0, 15), 1'($urandom));
            else
                idle();
            bus.execute_ready = ($urandom_range(0, 3) != 0);
            if ((n / 200) % 2 == 0) wb[15:0] = 16'($urandom | $urandom);
            else                    wb[15:0] = 16'($urandom & $urandom);
            flush = ($urandom_range(0, 39) == 0);
            rstn  = ($urandom_range(0, 199) != 0);
            cyc();
        end
        idle(); flush = 1'b0; rstn = 1'b1;
        cyc();
        #10;
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errs);
        $finish;
    end
endmodule
